// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver with a terminator-delimited message assembler.
// Optional parity bit: define UART_RX_PARITY_EN (sense set by PARITY_ODD).
//
// Ports:
//   clk_50M    system clock
//   rst        synchronous reset, active-high
//   rx         asynchronous serial line, idle high
//   rx_byte    last received character
//   rx_valid   one-cycle pulse when rx_byte updates
//   frame_err  one-cycle pulse when the stop bit samples 0
//   parity_err one-cycle pulse on parity mismatch (0 without parity)
//   msg_data   completed message, first byte in [7:0], unused bytes zero
//   msg_len    message byte count, terminator excluded
//   msg_req    message-available request
//   msg_ack    consumer acknowledge
//   msg_ovf    one-cycle pulse when a message is dropped
module uart_rx_frame #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned MSG_MAX    = 11,
    parameter logic [7:0]  TERM       = 8'h23,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                         clk_50M,
    input  logic                         rst,
    input  logic                         rx,
    output logic [DATA_BITS-1:0]         rx_byte,
    output logic                         rx_valid,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic [8*MSG_MAX-1:0]         msg_data,
    output logic [$clog2(MSG_MAX+1)-1:0] msg_len,
    output logic                         msg_req,
    input  logic                         msg_ack,
    output logic                         msg_ovf
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam int unsigned LEN_W = $clog2(MSG_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(DATA_BITS - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MSG_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BRK
    } state_t;

    // Receiver state
    logic                 rx_s1_q, rxs_q;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    // Assembler state
    logic [8*MSG_MAX-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]     buf_cnt_q, buf_cnt_d;
    logic [8*MSG_MAX-1:0] msg_data_q, msg_data_d;
    logic [LEN_W-1:0]     msg_len_q, msg_len_d;
    logic                 msg_req_q, msg_req_d;
    logic                 msg_ovf_q, msg_ovf_d;

    logic       ack_take;
    logic       err_pulse;
    logic [7:0] byte8;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    // A start bit that is high again at mid-bit was a glitch
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in from the top
                    shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_END) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    par_bad_d = rxs_q ^ (^shreg_q) ^ PARITY_ODD;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            rx_byte_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end
`else
                        rx_byte_d  = shreg_q;
                        rx_valid_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BRK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BRK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ack_take  = msg_req_q & msg_ack;
    assign err_pulse = frame_err_q | parity_err;
    assign byte8     = 8'(rx_byte_q);

    always_comb begin
        buf_d      = buf_q;
        buf_cnt_d  = buf_cnt_q;
        msg_data_d = msg_data_q;
        msg_len_d  = msg_len_q;
        msg_req_d  = msg_req_q;
        msg_ovf_d  = 1'b0;
        if (ack_take) begin
            msg_req_d  = 1'b0;
            msg_data_d = '0;
            msg_len_d  = '0;
        end
        if (err_pulse) begin
            buf_d     = '0;
            buf_cnt_d = '0;
        end else if (rx_valid_q) begin
            if (byte8 != TERM) begin
                if (buf_cnt_q < LEN_MAX) begin
                    for (int i = 0; i < int'(MSG_MAX); i++) begin
                        if (buf_cnt_q == LEN_W'(i)) begin
                            buf_d[8*i +: 8] = byte8;
                        end
                    end
                    buf_cnt_d = buf_cnt_q + 1'b1;
                end else begin
                    msg_ovf_d = 1'b1;
                    buf_d     = '0;
                    buf_cnt_d = '0;
                end
            end else if (buf_cnt_q != '0) begin
                // An ack taken this cycle frees the slot for the new message
                if (!msg_req_q || ack_take) begin
                    msg_data_d = buf_q;
                    msg_len_d  = buf_cnt_q;
                    msg_req_d  = 1'b1;
                end else begin
                    msg_ovf_d = 1'b1;
                end
                buf_d     = '0;
                buf_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
            buf_q       <= '0;
            buf_cnt_q   <= '0;
            msg_data_q  <= '0;
            msg_len_q   <= '0;
            msg_req_q   <= 1'b0;
            msg_ovf_q   <= 1'b0;
        end else begin
            rx_s1_q     <= rx;
            rxs_q       <= rx_s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
            buf_q       <= buf_d;
            buf_cnt_q   <= buf_cnt_d;
            msg_data_q  <= msg_data_d;
            msg_len_q   <= msg_len_d;
            msg_req_q   <= msg_req_d;
            msg_ovf_q   <= msg_ovf_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    // Parity sense has no role without a parity bit on the line
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign parity_err = 1'b0;
`endif

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign msg_data  = msg_data_q;
    assign msg_len   = msg_len_q;
    assign msg_req   = msg_req_q;
    assign msg_ovf   = msg_ovf_q;

endmodule
